// File: rtl/frame_write_ctrl_pkg.sv
// Shared frame-buffer geometry, capture state encoding and RGB565->RGB332 field positions.
// The frame buffer and VGA reader use the same constants.
package frame_write_ctrl_pkg;
  localparam int WIDTH  = 176;
  localparam int HEIGHT = 144;
  localparam int ADDR_W = 15;
  localparam int X_W    = $clog2(WIDTH + 1);
  localparam int Y_W    = $clog2(HEIGHT + 1);

  localparam logic [X_W-1:0]    X_MAX     = X_W'(WIDTH);
  localparam logic [Y_W-1:0]    Y_MAX     = Y_W'(HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);

  // First byte carries R[4:2] in [7:5] and G[5:3] in [2:0]; second byte carries B[4:3] in [4:3].
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 2;
  localparam int G_LSB = 0;
  localparam int B_MSB = 4;
  localparam int B_LSB = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
endpackage

// File: rtl/frame_write_ctrl_if.sv
// Camera byte stream in, frame-buffer write port and capture status out.
// No backpressure: the frame buffer must accept every w_en strobe.
interface frame_write_ctrl_if;
  import frame_write_ctrl_pkg::*;

  logic              start;
  logic              cont;
  logic              vsync;
  logic              href;
  logic [7:0]        cam_data;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;
  logic              w_en;
  logic              busy;
  logic              frame_done;
  logic [7:0]        frame_cnt;
  logic              clip_err;

  modport slave (
    input  start, cont, vsync, href, cam_data,
    output w_addr, w_data, w_en, busy, frame_done, frame_cnt, clip_err
  );

  modport master (
    output start, cont, vsync, href, cam_data,
    input  w_addr, w_data, w_en, busy, frame_done, frame_cnt, clip_err
  );
endinterface

// File: rtl/frame_write_ctrl_rgb565_to_332_packer.sv
// Pairs camera bytes into RGB332 pixels; pix_vld is combinational on the second byte.
// No backpressure; clr drops a dangling first byte.
module rgb565_to_332_packer
  import frame_write_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] cam_data,
  output logic       pix_vld,
  output rgb332_t    pix_dat
);
  logic       phase_q, phase_d;
  logic [2:0] r_q, r_d;
  logic [2:0] g_q, g_d;

  always_comb begin
    phase_d = phase_q;
    r_d     = r_q;
    g_d     = g_q;
    if (clr) begin
      phase_d = 1'b0;
    end else if (en) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        r_d = cam_data[R_MSB:R_LSB];
        g_d = cam_data[G_MSB:G_LSB];
      end
    end
  end

  assign pix_vld = en && phase_q && !clr;
  assign pix_dat = '{r: r_q, g: g_q, b: cam_data[B_MSB:B_LSB]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
    end else begin
      phase_q <= phase_d;
      r_q     <= r_d;
      g_q     <= g_d;
    end
  end
endmodule

// File: rtl/frame_write_ctrl.sv
// Camera capture sequencer driving the 176x144 RGB332 frame-buffer write port.
// Write lands one clk after the second byte of a pair; no backpressure.
module frame_write_ctrl
  import frame_write_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  frame_write_ctrl_if.slave  bus
);
  state_e            state_q, state_d;
  logic              vsync_d_q, href_d_q;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  rgb332_t           w_data_q, w_data_d;
  logic              w_en_q, w_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clip_q, clip_d;
  logic [7:0]        cnt_q, cnt_d;

  logic    in_cap, vs_rise, vs_fall, href_fall, cap_entry;
  logic    pix_vld;
  rgb332_t pix_dat;

  assign in_cap    = (state_q == CAPTURE);
  assign vs_rise   = !vsync_d_q && bus.vsync;
  assign vs_fall   = vsync_d_q && !bus.vsync;
  assign href_fall = in_cap && href_d_q && !bus.href;
  assign cap_entry = (state_q == WAIT_VS) && vs_fall;

  rgb565_to_332_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (in_cap && bus.href),
    .clr      (cap_entry || href_fall),
    .cam_data (bus.cam_data),
    .pix_vld  (pix_vld),
    .pix_dat  (pix_dat)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    line_base_d = line_base_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    w_en_d      = 1'b0;
    done_d      = 1'b0;
    clip_d      = clip_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: if (bus.start) state_d = WAIT_VS;
      WAIT_VS: begin
        if (vs_fall) begin
          state_d     = CAPTURE;
          x_d         = '0;
          y_d         = '0;
          line_base_d = '0;
          clip_d      = 1'b0;
        end
      end
      CAPTURE: begin
        if (vs_rise) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = bus.cont ? WAIT_VS : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // x and y saturate at the frame size, so line_base never passes WIDTH*HEIGHT.
    if (pix_vld) begin
      if (x_q < X_MAX && y_q < Y_MAX) begin
        w_en_d   = 1'b1;
        w_data_d = pix_dat;
        w_addr_d = line_base_q + ADDR_W'(x_q);
      end else begin
        clip_d = 1'b1;
      end
      if (x_q < X_MAX) x_d = x_q + X_W'(1);
    end

    if (href_fall) begin
      if (x_q != '0 && y_q < Y_MAX) begin
        y_d         = y_q + Y_W'(1);
        line_base_d = line_base_q + LINE_STEP;
      end
      x_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vsync_d_q   <= 1'b0;
      href_d_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      line_base_q <= '0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      w_en_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clip_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      vsync_d_q   <= bus.vsync;
      href_d_q    <= bus.href;
      x_q         <= x_d;
      y_q         <= y_d;
      line_base_q <= line_base_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      w_en_q      <= w_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clip_q      <= clip_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.w_addr     = w_addr_q;
  assign bus.w_data     = w_data_q;
  assign bus.w_en       = w_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.frame_cnt  = cnt_q;
  assign bus.clip_err   = clip_q;
endmodule

// File: tb/tb_frame_write_ctrl.sv
// Self-checking bench for frame_write_ctrl: expected writes are queued when bytes are driven
// and checked as the write strobes appear.
module tb_frame_write_ctrl;
  import frame_write_ctrl_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  frame_write_ctrl_if bus ();

  frame_write_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] px332(input logic [7:0] b0, input logic [7:0] b1);
    return {b0[7:5], b0[2:0], b1[4:3]};
  endfunction

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.w_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h (no write expected)", bus.w_addr, bus.w_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.w_addr !== e.addr || bus.w_data !== e.data) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h", bus.w_addr, bus.w_data, e.addr, e.data);
        end
      end
    end
    if (bus.frame_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic frame_open();
    tick();
    bus.vsync = 1'b1;
    repeat (2) tick();
    bus.vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic frame_close();
    bus.vsync = 1'b1;
    repeat (3) tick();
  endtask

  task automatic send_line(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                           input int base, input int nwrite);
    exp_t e;
    for (int i = 0; i < nwrite; i++) begin
      e.addr = ADDR_W'(base + i);
      e.data = px332(b0, b1);
      exp_q.push_back(e);
    end
    for (int i = 0; i < nbytes; i++) begin
      bus.href     = 1'b1;
      bus.cam_data = i[0] ? b1 : b0;
      tick();
    end
    bus.href     = 1'b0;
    bus.cam_data = 8'h00;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.cont     = 1'b0;
    bus.vsync    = 1'b0;
    bus.href     = 1'b0;
    bus.cam_data = 8'h00;
    repeat (3) tick();
    checks++;
    if ({bus.w_addr, bus.w_data, bus.w_en, bus.busy, bus.frame_done, bus.frame_cnt, bus.clip_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%0d data=%h en=%b busy=%b done=%b cnt=%0d clip=%b exp all 0",
               bus.w_addr, bus.w_data, bus.w_en, bus.busy, bus.frame_done, bus.frame_cnt, bus.clip_err);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_single_frame();
    int d0 = done_cnt;
    start_pulse();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL armed_busy got=%b exp=1", bus.busy);
    end
    frame_open();
    for (int y = 0; y < HEIGHT; y++) send_line(8'hE0, 8'h18, 2 * WIDTH, y * WIDTH, WIDTH);
    frame_close();
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL single_done_pulses got=%0d exp=1", done_cnt - d0);
    end
    checks++;
    if (bus.frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL single_frame_cnt got=%0d exp=1", bus.frame_cnt);
    end
    checks++;
    if (bus.clip_err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end_state got clip=%b busy=%b exp clip=0 busy=0", bus.clip_err, bus.busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_missing_writes got=%0d left exp=0", exp_q.size());
    end
  endtask

  task automatic test_packing_latency();
    exp_t e;
    start_pulse();
    frame_open();
    bus.href     = 1'b1;
    bus.cam_data = 8'hA5;
    tick();
    checks++;
    if (bus.w_en !== 1'b0) begin
      errors++;
      $display("FAIL lat_first_byte w_en got=%b exp=0", bus.w_en);
    end
    bus.cam_data = 8'h5A;
    e.addr = '0;
    e.data = px332(8'hA5, 8'h5A);
    exp_q.push_back(e);
    tick();
    checks++;
    if (bus.w_en !== 1'b1 || bus.w_data !== e.data || bus.w_addr !== e.addr) begin
      errors++;
      $display("FAIL lat_write got en=%b data=%h addr=%0d exp en=1 data=%h addr=%0d",
               bus.w_en, bus.w_data, bus.w_addr, e.data, e.addr);
    end
    bus.href     = 1'b0;
    bus.cam_data = 8'h00;
    tick();
    checks++;
    if (bus.w_en !== 1'b0) begin
      errors++;
      $display("FAIL lat_single_strobe w_en got=%b exp=0", bus.w_en);
    end
    frame_close();
    checks++;
    if (bus.frame_cnt !== 8'd2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL lat_frame got cnt=%0d left=%0d exp cnt=2 left=0", bus.frame_cnt, exp_q.size());
    end
  endtask

  task automatic test_long_line();
    start_pulse();
    frame_open();
    send_line(8'hE0, 8'h18, 360, 0, WIDTH);
    checks++;
    if (bus.clip_err !== 1'b1) begin
      errors++;
      $display("FAIL long_clip_err got=%b exp=1", bus.clip_err);
    end
    send_line(8'hA5, 8'h5A, 4, WIDTH, 2);
    checks++;
    if (exp_q.size() != 0 || bus.clip_err !== 1'b1) begin
      errors++;
      $display("FAIL long_next_line got left=%0d clip=%b exp left=0 clip=1", exp_q.size(), bus.clip_err);
    end
    frame_close();
    checks++;
    if (bus.frame_cnt !== 8'd3) begin
      errors++;
      $display("FAIL long_frame_cnt got=%0d exp=3", bus.frame_cnt);
    end
  endtask

  task automatic test_odd_byte();
    start_pulse();
    frame_open();
    checks++;
    if (bus.clip_err !== 1'b0) begin
      errors++;
      $display("FAIL clip_cleared_on_start got=%b exp=0", bus.clip_err);
    end
    send_line(8'hE0, 8'h18, 3, 0, 1);
    send_line(8'hA5, 8'h5A, 2, WIDTH, 1);
    frame_close();
    checks++;
    if (bus.frame_cnt !== 8'd4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL odd_frame got cnt=%0d left=%0d exp cnt=4 left=0", bus.frame_cnt, exp_q.size());
    end
  endtask

  task automatic test_continuous();
    int         d0 = done_cnt;
    logic [7:0] c0 = bus.frame_cnt;
    logic [7:0] b0;
    bus.cont = 1'b1;
    start_pulse();
    for (int f = 0; f < 3; f++) begin
      frame_open();
      if (f == 2) bus.cont = 1'b0;
      b0 = 8'h20 << f;
      send_line(b0 | 8'h03, 8'h08, 4, 0, 2);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      frame_close();
      checks++;
      if (bus.busy !== (f < 2)) begin
        errors++;
        $display("FAIL cont_busy frame=%0d got=%b exp=%b", f, bus.busy, f < 2);
      end
      if (f < 2) begin
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
      end
    end
    repeat (3) tick();
    checks++;
    if (done_cnt - d0 !== 3) begin
      errors++;
      $display("FAIL cont_done_pulses got=%0d exp=3", done_cnt - d0);
    end
    checks++;
    if (bus.frame_cnt !== 8'(c0 + 8'd3)) begin
      errors++;
      $display("FAIL cont_frame_cnt got=%0d exp=%0d", bus.frame_cnt, 8'(c0 + 8'd3));
    end
    checks++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL cont_end got busy=%b left=%0d exp busy=0 left=0", bus.busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_line();
    int   d0 = done_cnt;
    exp_t e;
    start_pulse();
    frame_open();
    for (int i = 0; i < 50; i++) begin
      e.addr = ADDR_W'(i);
      e.data = px332(8'hE0, 8'h18);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 100; i++) begin
      bus.href     = 1'b1;
      bus.cam_data = i[0] ? 8'h18 : 8'hE0;
      tick();
    end
    bus.cam_data = 8'hE0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.w_addr, bus.w_data, bus.w_en, bus.busy, bus.frame_done, bus.frame_cnt, bus.clip_err} !== '0) begin
      errors++;
      $display("FAIL midline_reset got addr=%0d data=%h en=%b busy=%b done=%b cnt=%0d clip=%b exp all 0",
               bus.w_addr, bus.w_data, bus.w_en, bus.busy, bus.frame_done, bus.frame_cnt, bus.clip_err);
    end
    for (int i = 0; i < 6; i++) begin
      bus.cam_data = i[0] ? 8'hE0 : 8'h18;
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.cam_data = i[0] ? 8'h18 : 8'hE0;
      tick();
    end
    bus.href = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0 || done_cnt != d0) begin
      errors++;
      $display("FAIL midline_after got busy=%b left=%0d done_delta=%0d exp busy=0 left=0 done_delta=0",
               bus.busy, exp_q.size(), done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_packing_latency();
    test_long_line();
    test_odd_byte();
    test_continuous();
    test_reset_mid_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
